// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: single-issue fetch FSM with decoder backpressure,
// branch redirect/flush and halt-opcode detection.
module instruction_fetch_controller #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  memAddress,
   input  logic [15:0] memData,
   output logic [15:0] instr,
   output logic [7:0]  instrPC,
   output logic        instrValid,
   input  logic        instrReady,
   input  logic        branchTaken,
   input  logic [7:0]  branchTarget,
   output logic        halted
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t      r_state, w_state_nxt;
   logic [7:0]  r_pc, r_instr_pc, w_pc_nxt;
   logic [15:0] r_instr;
   logic        r_valid, r_halted;
   logic        w_run, w_xfer, w_is_halt, w_load, w_valid_nxt;
   always_comb begin
      w_run       = r_state == RUN;
      w_xfer      = r_valid & instrReady;
      w_is_halt   = r_instr[15:8] == HALT_OPCODE;
      // a presented halt word blocks further fetch until it is accepted or flushed
      w_load      = w_run & !branchTaken & (!r_valid | instrReady) & !(r_valid & w_is_halt);
      w_state_nxt = w_run ? ((!branchTaken & w_xfer & w_is_halt) ? HALT : RUN)
                          : (start ? RUN : r_state);
      w_pc_nxt    = (w_run & branchTaken) ? branchTarget : w_load ? r_pc + 8'd2 : r_pc;
      w_valid_nxt = w_load | (w_run & r_valid & !w_xfer & !branchTaken);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= 16'h0000;
         r_instr_pc <= 8'h00;
         r_valid    <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_valid    <= w_valid_nxt;
         r_halted   <= w_state_nxt == HALT;
         r_instr    <= w_load ? memData : r_instr;
         r_instr_pc <= w_load ? r_pc : r_instr_pc;
      end
   end
   assign memAddress = r_pc;
   assign instr      = r_instr;
   assign instrPC    = r_instr_pc;
   assign instrValid = r_valid;
   assign halted     = r_halted;
endmodule
